cordic_arb: RTL and testbench
=============================

CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32, is the data width of every stream port (packed {I[31:16], Q[15:0]} at the default).
REQ-002 s00_axis_aclk  input  1  is the single clock; every register is updated on its rising edge.
REQ-003 s00_axis_areset  input  1  is the reset, synchronous and active-high.
REQ-004 s00_axis_tvalid/tlast  input  1 each, s00_axis_tdata  input  C_AXIS_TDATA_WIDTH, s00_axis_tstrb  input  C_AXIS_TDATA_WIDTH/8: requester 0 stream.
REQ-005 s00_axis_tready  output  1  is the requester 0 accept signal.
REQ-006 s01_axis_tvalid/tlast/tdata/tstrb  input, with the same widths as s00: requester 1 stream.
REQ-007 s01_axis_tready  output  1  is the requester 1 accept signal.
REQ-008 m00_axis_tready  input  1  is backpressure from the shared cordic.
REQ-009 m00_axis_tvalid/tlast  output  1 each, m00_axis_tdata  output  C_AXIS_TDATA_WIDTH, m00_axis_tstrb  output  C_AXIS_TDATA_WIDTH/8: stream to the shared cordic.
REQ-010 m00_axis_tuser  output  1  is the source ID of the current output beat (0 = s00, 1 = s01).
REQ-011 prio_mode  input  1  selects arbitration: 0 = round-robin, 1 = fixed priority to s00.
REQ-012 pkt_cnt0, pkt_cnt1  output  16 each  count packets accepted from s00 and s01.
REQ-013 busy  output  1  is high whenever state != IDLE.

Function
REQ-014 The block SHALL use a state machine with states IDLE, GRANT0 and GRANT1.
REQ-015 In IDLE, with both tready outputs low:
- one valid requester -> that requester is granted;
- both valid, prio_mode=1 -> GRANT0;
- both valid, prio_mode=0 -> the requester not granted most recently (rr pointer); the pointer after reset favours s00;
- no requester valid -> stay in IDLE.
REQ-016 prio_mode SHALL be sampled only in IDLE; a change during a grant does not affect the packet in flight.
REQ-017 In GRANTn, sn_axis_tready SHALL be (!m00_axis_tvalid || m00_axis_tready); the other requester's tready SHALL be 0.
REQ-018 On an accepted input beat, the output register SHALL load tdata/tstrb/tlast with tuser=n and set m00_axis_tvalid=1: 1-cycle latency, no combinational path from input to m00 data.
REQ-019 Output register behaviour:
- m00_axis_tvalid clears when m00_axis_tready=1 and no new beat is loaded in the same cycle;
- a simultaneous drain and load SHALL keep tvalid=1 with the new beat;
- full throughput of 1 beat/cycle while m00_axis_tready=1.
REQ-020 Output data/tlast/tstrb/tuser SHALL remain stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-021 An accepted beat with tlast=1 in GRANTn SHALL:
- move the state to IDLE;
- set the rr pointer to favour the other requester;
- increment pkt_cntn.
REQ-022 Packets SHALL never interleave: the grant is held until the tlast beat is accepted, regardless of the other requester's tvalid.
REQ-023 The IDLE cycle between packets is mandatory, giving 1 bubble cycle per packet at the input side.
REQ-024 pkt_cnt0/pkt_cnt1 SHALL saturate at 0xFFFF and not wrap.

Reset
REQ-025 During reset (s00_axis_areset=1) the block SHALL drive:
- state=IDLE, rr pointer favouring s00;
- m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0, m00_axis_tuser=0;
- s00_axis_tready=0, s01_axis_tready=0;
- pkt_cnt0=0, pkt_cnt1=0, busy=0.
REQ-026 Reset asserted mid-packet SHALL drop the partial packet and the pending output beat; no count is taken for the dropped packet.
REQ-027 After reset is released, arbitration SHALL restart from IDLE on the next edge.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Single source: s00 sends 4 beats 0x0001_0002..0x0004_0005 (tlast on beat 4), m00_tready=1 -> same 4 beats out, 1-cycle latency, tuser=0, pkt_cnt0=1.
- Round-robin contention: prio_mode=0, s00 and s01 each hold 3 packets of 2 beats -> output order s00,s01,s00,s01,s00,s01, no interleave, each pkt_cnt ends at 3.
- Fixed priority: prio_mode=1, both always valid -> only s00 is granted; s01 is granted only after s00 tvalid drops in IDLE.
- Backpressure: m00_tready toggles 1010... mid-packet -> output beats held stable while stalled, no beat lost or duplicated, tready to the granted source low whenever tvalid=1 and m00_tready=0.
- Reset mid-packet: assert reset after beat 2 of a 4-beat s01 packet -> all outputs at reset values on the next edge, pkt_cnt1 unchanged at 0, and a fresh s00 packet after release is granted normally.
- Saturation: 65537 single-beat s00 packets -> pkt_cnt0=0xFFFF.

Source files
------------

// File: rtl/cordic_arb_if.sv
// rtl/cordic_arb_if.sv - stream bundle shared by the requesters, the arbiter and the cordic
//
// Purpose: groups the three streams around cordic_arb so that they travel as one port.
// Signals:
//   s00_axis_* : requester 0 stream (tvalid/tdata/tstrb/tlast in, tready out of the arbiter)
//   s01_axis_* : requester 1 stream, same layout as s00
//   m00_axis_* : stream to the shared cordic (tvalid/tdata/tstrb/tlast/tuser out, tready in)
// Modports: master = environment side (requesters + cordic), slave = arbiter side.
interface cordic_arb_if #(
  parameter int C_AXIS_TDATA_WIDTH = 32
);
  logic                            s00_axis_tvalid;
  logic                            s00_axis_tlast;
  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb;
  logic                            s00_axis_tready;

  logic                            s01_axis_tvalid;
  logic                            s01_axis_tlast;
  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb;
  logic                            s01_axis_tready;

  logic                            m00_axis_tvalid;
  logic                            m00_axis_tlast;
  logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                            m00_axis_tuser;
  logic                            m00_axis_tready;

  modport master (
    output s00_axis_tvalid, s00_axis_tlast, s00_axis_tdata, s00_axis_tstrb,
    input  s00_axis_tready,
    output s01_axis_tvalid, s01_axis_tlast, s01_axis_tdata, s01_axis_tstrb,
    input  s01_axis_tready,
    input  m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb, m00_axis_tuser,
    output m00_axis_tready
  );

  modport slave (
    input  s00_axis_tvalid, s00_axis_tlast, s00_axis_tdata, s00_axis_tstrb,
    output s00_axis_tready,
    input  s01_axis_tvalid, s01_axis_tlast, s01_axis_tdata, s01_axis_tstrb,
    output s01_axis_tready,
    output m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb, m00_axis_tuser,
    input  m00_axis_tready
  );
endinterface

// File: rtl/cordic_arb.sv
// rtl/cordic_arb.sv - packet arbiter sharing one cordic between two stream requesters
//
// Purpose: grants one requester at a time for a whole packet (until its tlast beat) and
// forwards its beats through a single output register tagged with the source ID.
// Ports:
//   s00_axis_aclk   : clock, all state updates on the rising edge
//   s00_axis_areset : synchronous active-high reset
//   axis            : cordic_arb_if.slave, the s00/s01 requester streams and the m00 output
//   prio_mode       : 0 = round-robin between packets, 1 = s00 always wins contention
//   pkt_cnt0/1      : saturating counts of packets accepted from s00/s01
//   busy            : high while a requester holds the grant
module cordic_arb #(
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic         s00_axis_aclk,
  input  logic         s00_axis_areset,
  cordic_arb_if.slave  axis,
  input  logic         prio_mode,
  output logic [15:0]  pkt_cnt0,
  output logic [15:0]  pkt_cnt1,
  output logic         busy
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr;          // 0: s00 wins the next tie, 1: s01 wins it
  logic            r_m_tvalid;
  logic            r_m_tlast;
  logic            r_m_tuser;
  logic [W-1:0]    r_m_tdata;
  logic [SW-1:0]   r_m_tstrb;
  logic [15:0]     r_cnt0;
  logic [15:0]     r_cnt1;

  logic            w_out_free;
  logic            w_tready0;
  logic            w_tready1;
  logic            w_acc0;
  logic            w_acc1;

  // The output register can take a beat when it is empty or being drained this cycle,
  // which is what gives back-to-back throughput without a combinational data path.
  assign w_out_free = !r_m_tvalid || axis.m00_axis_tready;
  assign w_acc0     = w_tready0 && axis.s00_axis_tvalid;
  assign w_acc1     = w_tready1 && axis.s01_axis_tvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_tready0   = 1'b0;
    w_tready1   = 1'b0;
    case (r_state)
      IDLE: begin
        // prio_mode is only looked at here, so a packet in flight never changes owner.
        if (axis.s00_axis_tvalid &&
            (!axis.s01_axis_tvalid || prio_mode || !r_rr)) begin
          w_state_nxt = GRANT0;
        end else if (axis.s01_axis_tvalid) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        w_tready0 = w_out_free;
        if (w_tready0 && axis.s00_axis_tvalid && axis.s00_axis_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      GRANT1: begin
        w_tready1 = w_out_free;
        if (w_tready1 && axis.s01_axis_tvalid && axis.s01_axis_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state    <= IDLE;
      r_rr       <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tstrb  <= '0;
      r_cnt0     <= 16'd0;
      r_cnt1     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_acc0) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= axis.s00_axis_tdata;
        r_m_tstrb  <= axis.s00_axis_tstrb;
        r_m_tlast  <= axis.s00_axis_tlast;
        r_m_tuser  <= 1'b0;
      end else if (w_acc1) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= axis.s01_axis_tdata;
        r_m_tstrb  <= axis.s01_axis_tstrb;
        r_m_tlast  <= axis.s01_axis_tlast;
        r_m_tuser  <= 1'b1;
      end else if (axis.m00_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end

      // A finished packet hands the next tie to the other requester.
      if (w_acc0 && axis.s00_axis_tlast) begin
        r_rr <= 1'b1;
        if (r_cnt0 != 16'hFFFF) begin
          r_cnt0 <= r_cnt0 + 16'd1;
        end
      end
      if (w_acc1 && axis.s01_axis_tlast) begin
        r_rr <= 1'b0;
        if (r_cnt1 != 16'hFFFF) begin
          r_cnt1 <= r_cnt1 + 16'd1;
        end
      end
    end
  end

  assign axis.s00_axis_tready = w_tready0;
  assign axis.s01_axis_tready = w_tready1;
  assign axis.m00_axis_tvalid = r_m_tvalid;
  assign axis.m00_axis_tlast  = r_m_tlast;
  assign axis.m00_axis_tdata  = r_m_tdata;
  assign axis.m00_axis_tstrb  = r_m_tstrb;
  assign axis.m00_axis_tuser  = r_m_tuser;
  assign pkt_cnt0             = r_cnt0;
  assign pkt_cnt1             = r_cnt1;
  assign busy                 = (r_state != IDLE);

endmodule

// File: tb/tb_cordic_arb.sv
// tb/tb_cordic_arb.sv - self-checking bench for cordic_arb
module tb_cordic_arb;

  localparam int W  = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    bit prio;
    int prev;   // source of a packet sent beforehand to set up the tie-break, 2 = none
    bit v0;
    bit v1;
    int first;  // source expected to be granted first
  } arb_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        prio;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        busy;

  always #5 clk = ~clk;

  cordic_arb_if #(.C_AXIS_TDATA_WIDTH(W)) bus ();

  cordic_arb #(.C_AXIS_TDATA_WIDTH(W)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .axis            (bus.slave),
    .prio_mode       (prio),
    .pkt_cnt0        (cnt0),
    .pkt_cnt1        (cnt1),
    .busy            (busy)
  );

  beat_t       src_q[2][$];
  beat_t       exp_q[2][$];
  int          pkt_order[$];
  int unsigned sent[2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          gap_pct = 0;
  int          sink_mode = 0;
  bit          rand_prio = 0;
  arb_vec_t    tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] order_code();
    logic [63:0] c;
    c = 64'd1;
    foreach (pkt_order[i]) c = {c[62:0], pkt_order[i][0]};
    return c;
  endfunction

  task automatic set_src(input int s, input bit v, input beat_t b);
    if (s == 0) begin
      bus.s00_axis_tvalid = v;
      bus.s00_axis_tdata  = b.data;
      bus.s00_axis_tstrb  = b.strb;
      bus.s00_axis_tlast  = b.last;
    end else begin
      bus.s01_axis_tvalid = v;
      bus.s01_axis_tdata  = b.data;
      bus.s01_axis_tstrb  = b.strb;
      bus.s01_axis_tlast  = b.last;
    end
  endtask

  // Requester drivers: hold each beat until accepted, optional random gaps between beats.
  initial begin : drv
    bit a[2];
    bit v;
    set_src(0, 1'b0, '0);
    set_src(1, 1'b0, '0);
    forever begin
      @(negedge clk);
      a[0] = bus.s00_axis_tvalid && bus.s00_axis_tready;
      a[1] = bus.s01_axis_tvalid && bus.s01_axis_tready;
      @(posedge clk);
      #1;
      if (rst) begin
        src_q[0].delete();
        src_q[1].delete();
        set_src(0, 1'b0, '0);
        set_src(1, 1'b0, '0);
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (a[s]) begin
            void'(src_q[s].pop_front());
            set_src(s, 1'b0, '0);
          end
          v = (s == 0) ? bus.s00_axis_tvalid : bus.s01_axis_tvalid;
          if (!v && src_q[s].size() > 0 && $urandom_range(99) >= gap_pct)
            set_src(s, 1'b1, src_q[s][0]);
        end
      end
    end
  end

  // Cordic side: always ready, 1010 toggling, or random.
  initial begin : sink
    bus.m00_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       bus.m00_axis_tready = 1'b1;
        1:       bus.m00_axis_tready = ~bus.m00_axis_tready;
        default: bus.m00_axis_tready = 1'($urandom_range(1));
      endcase
    end
  end

  // Scoreboard: each source's beats must leave in order, once, one cycle after acceptance,
  // whole packets at a time, and stay frozen while stalled.
  initial begin : mon
    beat_t        e;
    bit           held_v;
    logic [37:0]  held;
    bit           pend[2];
    logic [W-1:0] pend_d[2];
    bit           in_pkt;
    int           cur_src;
    int           s;
    held_v = 0; pend[0] = 0; pend[1] = 0; in_pkt = 0; cur_src = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q[0].delete();
        exp_q[1].delete();
        held_v = 0; pend[0] = 0; pend[1] = 0; in_pkt = 0;
        continue;
      end
      for (int k = 0; k < 2; k++) begin
        if (pend[k])
          chk("latency", 64'({bus.m00_axis_tvalid, bus.m00_axis_tuser, bus.m00_axis_tdata}),
              64'({1'b1, 1'(k), pend_d[k]}));
      end
      if (held_v)
        chk("hold", 64'({bus.m00_axis_tvalid, bus.m00_axis_tuser, bus.m00_axis_tlast,
                         bus.m00_axis_tstrb, bus.m00_axis_tdata}), 64'({1'b1, held}));
      if (bus.m00_axis_tvalid && !bus.m00_axis_tready)
        chk("stall_tready", 64'({bus.s00_axis_tready, bus.s01_axis_tready}), 64'd0);
      if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
        s = int'(bus.m00_axis_tuser);
        if (in_pkt) chk("interleave", 64'(s), 64'(cur_src));
        if (exp_q[s].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got src %0d data %0h, required none", s, bus.m00_axis_tdata);
        end else begin
          e = exp_q[s].pop_front();
          chk("beat", 64'({bus.m00_axis_tdata, bus.m00_axis_tstrb, bus.m00_axis_tlast}), 64'(e));
        end
        in_pkt  = !bus.m00_axis_tlast;
        cur_src = s;
        if (bus.m00_axis_tlast) pkt_order.push_back(s);
      end
      held_v    = bus.m00_axis_tvalid && !bus.m00_axis_tready;
      held      = {bus.m00_axis_tuser, bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_tdata};
      pend[0]   = bus.s00_axis_tvalid && bus.s00_axis_tready;
      pend[1]   = bus.s01_axis_tvalid && bus.s01_axis_tready;
      pend_d[0] = bus.s00_axis_tdata;
      pend_d[1] = bus.s01_axis_tdata;
    end
  end

  task automatic enqueue_pkt(input int s, input int len, input logic [W-1:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? W'($urandom) : base + W'(i) * 32'h0001_0001;
      b.strb = rnd ? SW'($urandom) : {SW{1'b1}};
      b.last = (i == len - 1);
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
    sent[s]++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (rand_prio) prio = 1'($urandom_range(1));
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && !bus.m00_axis_tvalid && !busy &&
          !bus.s00_axis_tvalid && !bus.s01_axis_tvalid) break;
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: waited %0d cycles, required idle within %0d", name, n, budget);
    end
  endtask

  task automatic end_phase(input string name);
    int unsigned e0, e1;
    e0 = (sent[0] > 65535) ? 65535 : sent[0];
    e1 = (sent[1] > 65535) ? 65535 : sent[1];
    chk({name, "_cnt0"}, 64'(cnt0), 64'(e0));
    chk({name, "_cnt1"}, 64'(cnt1), 64'(e1));
    chk({name, "_lost"}, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sent[0] = 0;
    sent[1] = 0;
    @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_m00", 64'({bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tuser,
                          bus.m00_axis_tstrb, bus.m00_axis_tdata}), 64'd0);
      chk("rst_tready", 64'({bus.s00_axis_tready, bus.s01_axis_tready}), 64'd0);
      chk("rst_cnt", 64'({cnt0, cnt1}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_order.delete();
  endtask

  initial begin : main
    int k;
    rst  = 1'b1;
    prio = 1'b0;
    sent[0] = 0;
    sent[1] = 0;

    tbl[0] = '{0, 2, 1, 1, 0};
    tbl[1] = '{1, 2, 1, 1, 0};
    tbl[2] = '{0, 0, 1, 1, 1};
    tbl[3] = '{1, 0, 1, 1, 0};
    tbl[4] = '{0, 1, 1, 1, 0};
    tbl[5] = '{1, 1, 1, 1, 0};
    tbl[6] = '{0, 2, 0, 1, 1};
    tbl[7] = '{0, 2, 1, 0, 0};
    tbl[8] = '{1, 0, 0, 1, 1};
    tbl[9] = '{0, 1, 0, 1, 1};

    do_reset(1'b1);

    // single source, 4 beats
    sink_mode = 0;
    gap_pct   = 0;
    enqueue_pkt(0, 4, 32'h0001_0002, 1'b0);
    wait_idle("single", 200);
    chk("single_order", order_code(), 64'h2);
    end_phase("single");

    // arbitration decision table
    foreach (tbl[i]) begin
      do_reset(1'b0);
      prio = tbl[i].prio;
      if (tbl[i].prev != 2) begin
        enqueue_pkt(tbl[i].prev, 1, 32'h0A0A_0000, 1'b0);
        wait_idle("tbl_prev", 100);
        pkt_order.delete();
      end
      if (tbl[i].v0) enqueue_pkt(0, 1, 32'h1000_0000 + W'(i), 1'b0);
      if (tbl[i].v1) enqueue_pkt(1, 1, 32'h2000_0000 + W'(i), 1'b0);
      wait_idle("tbl", 100);
      chk($sformatf("tbl%0d_first", i),
          64'((pkt_order.size() > 0) ? pkt_order[0] : 9), 64'(tbl[i].first));
      end_phase($sformatf("tbl%0d", i));
    end

    // round-robin contention
    do_reset(1'b0);
    prio = 1'b0;
    for (int p = 0; p < 3; p++) begin
      enqueue_pkt(0, 2, 32'h0100_0000 + W'(p << 8), 1'b0);
      enqueue_pkt(1, 2, 32'h0200_0000 + W'(p << 8), 1'b0);
    end
    wait_idle("rr", 300);
    chk("rr_order", order_code(), 64'h55);
    end_phase("rr");

    // fixed priority
    do_reset(1'b0);
    prio = 1'b1;
    for (int p = 0; p < 3; p++) enqueue_pkt(0, 2, 32'h0300_0000 + W'(p << 8), 1'b0);
    for (int p = 0; p < 2; p++) enqueue_pkt(1, 2, 32'h0400_0000 + W'(p << 8), 1'b0);
    wait_idle("prio", 300);
    chk("prio_order", order_code(), 64'h23);
    end_phase("prio");

    // backpressure 1010...
    do_reset(1'b0);
    prio      = 1'b0;
    sink_mode = 1;
    enqueue_pkt(0, 5, 32'h0500_0000, 1'b0);
    enqueue_pkt(1, 3, 32'h0600_0000, 1'b0);
    wait_idle("bp", 300);
    chk("bp_order", order_code(), 64'h5);
    end_phase("bp");

    // randomized traffic, gaps, random stalls, prio_mode flipping mid-packet
    for (int r = 0; r < 2; r++) begin
      do_reset(1'b0);
      sink_mode = 2;
      gap_pct   = 30;
      rand_prio = 1'b1;
      for (int p = 0; p < 24; p++) begin
        enqueue_pkt(0, int'($urandom_range(4, 1)), '0, 1'b1);
        enqueue_pkt(1, int'($urandom_range(4, 1)), '0, 1'b1);
      end
      wait_idle("rand", 5000);
      rand_prio = 1'b0;
      end_phase("rand");
    end
    gap_pct   = 0;
    sink_mode = 0;
    prio      = 1'b0;

    // reset after beat 2 of a 4-beat s01 packet
    do_reset(1'b0);
    enqueue_pkt(1, 4, 32'h0700_0000, 1'b0);
    k = 0;
    for (int c = 0; c < 50 && k < 2; c++) begin
      @(negedge clk);
      if (bus.s01_axis_tvalid && bus.s01_axis_tready) k++;
    end
    chk("rstmid_beats_seen", 64'(k), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_m00", 64'({bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tuser,
                           bus.m00_axis_tstrb, bus.m00_axis_tdata}), 64'd0);
    chk("rstmid_tready", 64'({bus.s00_axis_tready, bus.s01_axis_tready}), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_cnt", 64'({cnt0, cnt1}), 64'd0);
    sent[0] = 0;
    sent[1] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_order.delete();
    enqueue_pkt(0, 2, 32'h0800_0000, 1'b0);
    wait_idle("rstmid", 100);
    chk("rstmid_order", order_code(), 64'h2);
    end_phase("rstmid");

    // saturation: 65537 single-beat s00 packets
    do_reset(1'b0);
    for (int p = 0; p < 65537; p++) enqueue_pkt(0, 1, W'(p), 1'b0);
    wait_idle("sat", 140000);
    chk("sat_cnt0", 64'(cnt0), 64'hFFFF);
    end_phase("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
